// File: rtl/td4_prog_ctrl.sv
// TD4 program store and run controller.
// Loads 16 instruction bytes and gates the core clock for run/step/halt/breakpoint.
module td4_prog_ctrl #(
    parameter logic [7:0] MEM_INIT = 8'h00,
    parameter int         CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic [7:0]       load_data,
    output logic             load_ready,
    output logic             load_done,
    input  logic             run,
    input  logic             step,
    input  logic             halt,
    input  logic             bp_en,
    input  logic [3:0]       bp_addr,
    input  logic [3:0]       cpu_addr,
    output logic [7:0]       cpu_data,
    output logic             cpu_en,
    output logic             cpu_rst,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] exec_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_STEP = 2'b11
    } state_t;

    state_t     st;
    logic [7:0] mem [16];
    logic [3:0] wr_ptr;
    logic       bp_skip;
    logic       bp_hit;

    assign state      = st;
    assign halted     = (st == S_IDLE);
    assign load_ready = (st == S_LOAD);
    assign cpu_data   = mem[cpu_addr];

    always_comb begin
        bp_hit = bp_en && (cpu_addr == bp_addr) && !bp_skip;
        cpu_en = 1'b0;
        case (st)
            S_RUN:   cpu_en = !bp_hit && !halt;
            S_STEP:  cpu_en = 1'b1;
            default: cpu_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_IDLE;
            for (int i = 0; i < 16; i++) mem[i] <= MEM_INIT;
            wr_ptr    <= 4'd0;
            cpu_rst   <= 1'b1;
            bp_skip   <= 1'b0;
            exec_cnt  <= '0;
            load_done <= 1'b0;
        end else begin
            load_done <= 1'b0;
            // an executed edge consumes any pending breakpoint skip
            if (cpu_en) begin
                exec_cnt <= exec_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                bp_skip  <= 1'b0;
            end
            case (st)
                S_IDLE: begin
                    if (load_start) begin
                        st       <= S_LOAD;
                        wr_ptr   <= 4'd0;
                        cpu_rst  <= 1'b1;
                        exec_cnt <= '0;
                        bp_skip  <= 1'b0;
                    end else if (run) begin
                        st      <= S_RUN;
                        cpu_rst <= 1'b0;
                    end else if (step) begin
                        st      <= S_STEP;
                        cpu_rst <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (halt) begin
                        st <= S_IDLE;
                    end else if (load_valid) begin
                        mem[wr_ptr] <= load_data;
                        wr_ptr      <= wr_ptr + 4'd1;
                        if (wr_ptr == 4'hF) begin
                            st        <= S_IDLE;
                            load_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (halt) begin
                        st <= S_IDLE;
                    end else if (bp_hit) begin
                        st      <= S_IDLE;
                        bp_skip <= 1'b1;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_td4_prog_ctrl.sv
// Bench for td4_prog_ctrl: table-driven memory reads through a scoreboard queue
// plus hand-written load/run/breakpoint/step/reset sequences with a tiny core model.
module tb_td4_prog_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_start, load_valid, load_ready, load_done;
    logic [7:0] load_data;
    logic       run, step, halt, bp_en;
    logic [3:0] bp_addr, cpu_addr;
    logic [7:0] cpu_data;
    logic       cpu_en, cpu_rst, halted;
    logic [1:0] state;
    logic [7:0] exec_cnt;

    logic [3:0] pc;
    logic [3:0] addr_ovr;
    logic       addr_ovr_en;
    int         done_cnt;
    int         total, bad;
    logic [7:0] img [16];
    logic [7:0] exp_q [$];

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } vec_t;
    vec_t vecs [32];

    td4_prog_ctrl #(.MEM_INIT(8'h00), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready),
        .load_done(load_done), .run(run), .step(step), .halt(halt),
        .bp_en(bp_en), .bp_addr(bp_addr), .cpu_addr(cpu_addr),
        .cpu_data(cpu_data), .cpu_en(cpu_en), .cpu_rst(cpu_rst),
        .halted(halted), .state(state), .exec_cnt(exec_cnt)
    );

    always #5 clk = ~clk;

    assign cpu_addr = addr_ovr_en ? addr_ovr : pc;

    // minimal core: JMP (Fx) loads pc, anything else falls through
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 4'd0;
        else if (cpu_rst) pc <= 4'd0;
        else if (cpu_en) begin
            if (cpu_data[7:4] == 4'hF) pc <= cpu_data[3:0];
            else pc <= pc + 4'd1;
        end
    end

    always @(posedge clk) if (load_done) done_cnt <= done_cnt + 1;

    function automatic logic [7:0] img1_byte(input int i);
        if (i == 0) return 8'h31;
        if (i == 1) return 8'h00;
        return 8'hA0 | 8'(i);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic check_vecs(input int lo, input int hi);
        addr_ovr_en = 1'b1;
        for (int i = lo; i < hi; i++) begin
            addr_ovr = vecs[i].addr;
            exp_q.push_back(vecs[i].data);
            #1;
            chk($sformatf("rd[%0d]", i), cpu_data, exp_q.pop_front());
        end
        addr_ovr_en = 1'b0;
    endtask

    // n bytes from img; abort=1 sends one more byte together with halt
    task automatic do_load(input int n, input bit abort, input bit gap);
        int d0;
        d0 = done_cnt;
        @(negedge clk) load_start = 1'b1;
        @(negedge clk) load_start = 1'b0;
        chk("load_ready_in_load", load_ready, 1);
        chk("state_load", state, 2'b01);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                load_valid = 1'b0;
                @(negedge clk);
            end
            load_valid = 1'b1;
            load_data  = img[i];
            @(negedge clk);
            load_valid = 1'b0;
        end
        if (abort) begin
            load_valid = 1'b1;
            load_data  = 8'hEE;
            halt       = 1'b1;
            @(negedge clk);
            load_valid = 1'b0;
            halt       = 1'b0;
            chk("abort_state", state, 2'b00);
            chk("abort_no_done", load_done, 0);
        end else begin
            chk("load_end_state", state, 2'b00);
            chk("load_done_pulse", load_done, 1);
            chk("load_ready_idle", load_ready, 0);
        end
        @(negedge clk);
        chk("load_done_low", load_done, 0);
        chk("load_done_count", done_cnt - d0, abort ? 0 : 1);
    endtask

    initial begin
        total = 0; bad = 0; done_cnt = 0;
        rst_n = 1'b1;
        load_start = 0; load_valid = 0; load_data = 0;
        run = 0; step = 0; halt = 0; bp_en = 0; bp_addr = 0;
        addr_ovr = 0; addr_ovr_en = 0;
        for (int i = 0; i < 16; i++) begin
            vecs[i]      = '{addr: 4'(i), data: img1_byte(i)};
            vecs[16 + i] = '{addr: 4'(i),
                             data: (i < 5) ? 8'h50 + 8'(i) : img1_byte(i)};
        end

        #3 rst_n = 1'b0;
        #1;
        chk("rst_state", state, 2'b00);
        chk("rst_halted", halted, 1);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_exec_cnt", exec_cnt, 0);
        chk("rst_mem0", cpu_data, 8'h00);
        @(negedge clk) rst_n = 1'b1;

        // full load, valid every other cycle
        for (int i = 0; i < 16; i++) img[i] = img1_byte(i);
        do_load(16, 1'b0, 1'b1);
        check_vecs(0, 16);

        // abort after 5 bytes; the 6th arrives with halt and is dropped
        for (int i = 0; i < 16; i++) img[i] = 8'h50 + 8'(i);
        do_load(5, 1'b1, 1'b0);
        check_vecs(16, 32);
        chk("abort_cpu_rst", cpu_rst, 1);

        // ADD A,1 / JMP 0 loop: 10 executed edges then halt
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
        img[0] = 8'h01;
        img[1] = 8'hF0;
        do_load(16, 1'b0, 1'b0);
        chk("load_clears_cnt", exec_cnt, 0);
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
        chk("run_cpu_rst", cpu_rst, 0);
        chk("run_state", state, 2'b10);
        repeat (10) @(negedge clk);
        halt = 1'b1;
        #1 chk("halt_cpu_en", cpu_en, 0);
        @(negedge clk) halt = 1'b0;
        chk("halt_exec_cnt", exec_cnt, 10);
        chk("halt_halted", halted, 1);
        chk("halt_cpu_rst", cpu_rst, 0);
        chk("halt_pc", pc, 0);

        // linear program, breakpoint at 3
        for (int i = 0; i < 16; i++) img[i] = 8'h01;
        do_load(16, 1'b0, 1'b0);
        bp_en = 1'b1;
        bp_addr = 4'd3;
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
        for (int k = 0; k < 20 && state != 2'b00; k++) @(negedge clk);
        chk("bp_stop_state", state, 2'b00);
        chk("bp_stop_pc", pc, 3);
        chk("bp_stop_cnt", exec_cnt, 3);
        run = 1'b1;
        @(negedge clk) run = 1'b0;
        #1 chk("bp_resume_en", cpu_en, 1);
        repeat (5) @(negedge clk);
        halt = 1'b1;
        @(negedge clk) halt = 1'b0;
        chk("bp_resume_pc", pc, 8);
        chk("bp_resume_cnt", exec_cnt, 8);

        // single steps with the breakpoint on the current pc, halt ignored
        for (int k = 0; k < 3; k++) begin
            bp_addr = pc;
            step = 1'b1;
            @(negedge clk) step = 1'b0;
            if (k == 2) halt = 1'b1;
            #1;
            chk("step_state", state, 2'b11);
            chk("step_cpu_en", cpu_en, 1);
            @(negedge clk) halt = 1'b0;
            chk("step_back_idle", state, 2'b00);
        end
        chk("step_cnt", exec_cnt, 11);
        chk("step_pc", pc, 11);

        // async reset between edges while running
        bp_en = 1'b0;
        run = 1'b1;
        @(negedge clk) run = 1'b0;
        #1 chk("pre_rst_en", cpu_en, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cpu_en", cpu_en, 0);
        chk("arst_cpu_rst", cpu_rst, 1);
        chk("arst_state", state, 2'b00);
        chk("arst_cnt", exec_cnt, 0);
        for (int i = 0; i < 16; i++) vecs[i] = '{addr: 4'(i), data: 8'h00};
        check_vecs(0, 16);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
